// File: rtl/blk_thread_sched.sv
`default_nettype none
// ============================================================================
// Module      : blk_thread_sched
// Description : Per-block thread scheduler in front of create_blk. Tracks
//               which threads have a block pending, issues them to create_blk
//               in round-robin order, re-queues unfinished computations and
//               reports finished ones on comp_done. A watchdog bounds the wait
//               for blk_end.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK            in   clock
//   RST_N          in   asynchronous active-low reset
//   req_wr_en      in   enqueue request for req_thread_num
//   req_thread_num in   thread to enqueue
//   req_new_comp   in   request starts a new computation
//   blk_end        in   1-cycle pulse: current block finished
//   comp_fin       in   valid with blk_end: computation finished
//   blk_start      out  1-cycle pulse to create_blk
//   new_comp       out  valid with blk_start
//   thread_num     out  thread of the current block
//   busy           out  block in flight
//   pending        out  per-thread pending bits
//   comp_done      out  1-cycle pulse: thread_num finished its computation
//   err            out  sticky protocol violation / watchdog expiry
// ============================================================================
module blk_thread_sched #(
  parameter int N_THREADS     = 8,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int TIMEOUT_MSB   = 7
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     req_wr_en,
  input  logic [N_THREADS_MSB:0]   req_thread_num,
  input  logic                     req_new_comp,
  input  logic                     blk_end,
  input  logic                     comp_fin,
  output logic                     blk_start,
  output logic                     new_comp,
  output logic [N_THREADS_MSB:0]   thread_num,
  output logic                     busy,
  output logic [N_THREADS-1:0]     pending,
  output logic                     comp_done,
  output logic                     err
);

  localparam int TW = N_THREADS_MSB + 1;  // thread index width
  localparam int SW = TW + 1;             // scan width (room for ptr + offset)

  localparam logic [0:0] c_st_idle     = 1'b0;
  localparam logic [0:0] c_st_wait_end = 1'b1;

  localparam logic [TW-1:0] c_last_thread = TW'(N_THREADS - 1);
  // Watchdog trips on the cycle its count would reach 2^(TIMEOUT_MSB+1)-1.
  localparam logic [TIMEOUT_MSB:0] c_wdog_last = ~((TIMEOUT_MSB + 1)'(1));

  logic [0:0]           r_state, w_state_next;
  logic [N_THREADS-1:0] r_pending, w_pending_next;
  logic [N_THREADS-1:0] r_nc, w_nc_next;
  logic [TW-1:0]        r_rr_ptr;
  logic [TW-1:0]        r_thread_num;
  logic [TIMEOUT_MSB:0] r_wdog;
  logic                 r_blk_start, r_new_comp, r_busy, r_comp_done, r_err;

  logic                 w_any;
  logic [TW-1:0]        w_winner;
  logic                 w_issue, w_end, w_timeout, w_stray_end;
  logic                 w_req_in_range, w_req_pend_hit, w_req_busy_hit;
  logic                 w_req_ok, w_req_bad;

  // First set bit at or after ptr, wrapping N_THREADS-1 -> 0.
  function automatic logic [TW:0] f_rr_pick(input logic [N_THREADS-1:0] req,
                                            input logic [TW-1:0]        ptr);
    logic [SW-1:0] scan;
    logic          found;
    logic [TW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_THREADS; i++) begin
      scan = {1'b0, ptr} + SW'(i);
      if (scan >= SW'(N_THREADS)) scan = scan - SW'(N_THREADS);
      if (!found && req[scan[TW-1:0]]) begin
        found = 1'b1;
        idx   = scan[TW-1:0];
      end
    end
    return {found, idx};
  endfunction

  assign {w_any, w_winner} = f_rr_pick(r_pending, r_rr_ptr);

  // A request is refused if the thread is already queued or is the one whose
  // block is in flight (including the blk_end cycle itself).
  assign w_req_in_range = (req_thread_num <= c_last_thread);
  assign w_req_pend_hit = w_req_in_range && r_pending[req_thread_num];
  assign w_req_busy_hit = r_busy && (req_thread_num == r_thread_num);
  assign w_req_ok       = req_wr_en && w_req_in_range && !w_req_pend_hit && !w_req_busy_hit;
  assign w_req_bad      = req_wr_en && !w_req_ok;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= c_st_idle;
    else        r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:     if (w_any) w_state_next = c_st_wait_end;
      c_st_wait_end: if (blk_end || w_timeout) w_state_next = c_st_idle;
      default:       w_state_next = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: decoded actions
  // --------------------------------------------------------------------------
  always_comb begin
    w_issue     = 1'b0;
    w_end       = 1'b0;
    w_timeout   = 1'b0;
    w_stray_end = 1'b0;
    case (r_state)
      c_st_idle: begin
        w_issue     = w_any;
        w_stray_end = blk_end;
      end
      c_st_wait_end: begin
        w_end     = blk_end;
        // blk_end arriving on the expiry cycle still wins.
        w_timeout = !blk_end && (r_wdog == c_wdog_last);
      end
      default: w_stray_end = blk_end;
    endcase
  end

  // Pending / new-computation bit updates. Issue and re-queue are mutually
  // exclusive by state; a request never targets the winner or the in-flight
  // thread because those cases are refused above.
  always_comb begin
    w_pending_next = r_pending;
    w_nc_next      = r_nc;
    if (w_issue) begin
      w_pending_next[w_winner] = 1'b0;
      w_nc_next[w_winner]      = 1'b0;
    end
    if (w_end && !comp_fin) begin
      w_pending_next[r_thread_num] = 1'b1;
      w_nc_next[r_thread_num]      = 1'b0;
    end
    if (w_req_ok) begin
      w_pending_next[req_thread_num] = 1'b1;
      w_nc_next[req_thread_num]      = req_new_comp;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pending    <= '0;
      r_nc         <= '0;
      r_rr_ptr     <= '0;
      r_thread_num <= '0;
      r_wdog       <= '0;
      r_blk_start  <= 1'b0;
      r_new_comp   <= 1'b0;
      r_busy       <= 1'b0;
      r_comp_done  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_pending   <= w_pending_next;
      r_nc        <= w_nc_next;
      r_blk_start <= w_issue;
      r_new_comp  <= w_issue && r_nc[w_winner];
      r_comp_done <= w_end && comp_fin;
      r_err       <= r_err || w_req_bad || w_stray_end || w_timeout;

      if (w_issue) begin
        r_thread_num <= w_winner;
        r_rr_ptr     <= (w_winner == c_last_thread) ? '0 : w_winner + 1'b1;
      end

      if (w_issue)                r_busy <= 1'b1;
      else if (w_end || w_timeout) r_busy <= 1'b0;

      if ((r_state == c_st_wait_end) && !w_end && !w_timeout) r_wdog <= r_wdog + 1'b1;
      else                                                    r_wdog <= '0;
    end
  end

  assign blk_start  = r_blk_start;
  assign new_comp   = r_new_comp;
  assign thread_num = r_thread_num;
  assign busy       = r_busy;
  assign pending    = r_pending;
  assign comp_done  = r_comp_done;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_blk_thread_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_blk_thread_sched
// Description : Self-checking bench for blk_thread_sched (8 threads, 4-bit
//               watchdog). Expected issues are queued as stimulus is driven
//               and compared against blk_start events captured by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_blk_thread_sched;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       req_wr_en = 1'b0;
  logic [2:0] req_thread_num = 3'd0;
  logic       req_new_comp = 1'b0;
  logic       blk_end = 1'b0;
  logic       comp_fin = 1'b0;
  logic       blk_start, new_comp, busy, comp_done, err;
  logic [2:0] thread_num;
  logic [7:0] pending;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [2:0] thr;
    logic       nc;
  } iss_t;

  iss_t q_obs[$];
  iss_t q_exp[$];

  blk_thread_sched #(
    .N_THREADS   (8),
    .TIMEOUT_MSB (3)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .req_wr_en      (req_wr_en),
    .req_thread_num (req_thread_num),
    .req_new_comp   (req_new_comp),
    .blk_end        (blk_end),
    .comp_fin       (comp_fin),
    .blk_start      (blk_start),
    .new_comp       (new_comp),
    .thread_num     (thread_num),
    .busy           (busy),
    .pending        (pending),
    .comp_done      (comp_done),
    .err            (err)
  );

  always #5 CLK = ~CLK;

  // Capture every issued block.
  always @(posedge CLK) begin
    #1;
    if (blk_start === 1'b1) q_obs.push_back('{thr: thread_num, nc: new_comp});
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset;
    RST_N = 1'b0; req_wr_en = 1'b0; blk_end = 1'b0; comp_fin = 1'b0;
    cyc(2);
    q_obs.delete();
    q_exp.delete();
    RST_N = 1'b1;
    cyc(1);
  endtask

  task automatic enq(input int t, input bit nc);
    req_wr_en = 1'b1; req_thread_num = 3'(t); req_new_comp = nc;
    cyc(1);
    req_wr_en = 1'b0;
  endtask

  task automatic end_blk(input bit fin);
    blk_end = 1'b1; comp_fin = fin;
    cyc(1);
    blk_end = 1'b0; comp_fin = 1'b0;
  endtask

  task automatic wait_obs(output bit ok);
    for (int i = 0; i < 40 && q_obs.size() == 0; i++) cyc(1);
    ok = (q_obs.size() != 0);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    #2 RST_N = 1'b0;
    #1;
    n_vec++; if ({blk_start, new_comp, busy, comp_done, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {blk_start, new_comp, busy, comp_done, err}); end
    n_vec++; if (thread_num !== 3'd0) begin
      n_fail++; $display("FAIL reset_thread: got %0d want 0", thread_num); end
    n_vec++; if (pending !== 8'h00) begin
      n_fail++; $display("FAIL reset_pending: got %h want 00", pending); end
    cyc(2);
    RST_N = 1'b1;
    cyc(4);
    n_vec++; if (q_obs.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: issues=%0d busy=%b want 0/0", q_obs.size(), busy); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_single;
    iss_t o, e;
    do_reset;
    q_exp.push_back('{thr: 3'd3, nc: 1'b1});
    q_exp.push_back('{thr: 3'd3, nc: 1'b0});
    enq(3, 1'b1);                                   // now in cycle 1
    n_vec++; if (pending !== 8'h08 || blk_start !== 1'b0) begin
      n_fail++; $display("FAIL single_c1: pending=%h blk_start=%b want 08/0", pending, blk_start); end
    cyc(1);                                         // cycle 2
    n_vec++; if (blk_start !== 1'b1 || busy !== 1'b1 || pending !== 8'h00) begin
      n_fail++; $display("FAIL single_c2: blk_start=%b busy=%b pending=%h want 1/1/00", blk_start, busy, pending); end
    e = q_exp.pop_front();
    n_vec++;
    if (q_obs.size() == 0) begin
      n_fail++; $display("FAIL single_issue1: no blk_start seen, want thr=%0d nc=%b", e.thr, e.nc);
    end else begin
      o = q_obs.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL single_issue1: thr=%0d nc=%b want thr=%0d nc=%b", o.thr, o.nc, e.thr, e.nc); end
    end
    cyc(8);                                         // cycle 10
    end_blk(1'b0);                                  // cycle 11
    n_vec++; if (pending !== 8'h08 || busy !== 1'b0 || comp_done !== 1'b0) begin
      n_fail++; $display("FAIL single_requeue: pending=%h busy=%b comp_done=%b want 08/0/0", pending, busy, comp_done); end
    cyc(1);                                         // cycle 12
    e = q_exp.pop_front();
    n_vec++;
    if (blk_start !== 1'b1 || q_obs.size() == 0) begin
      n_fail++; $display("FAIL single_issue2: blk_start=%b at cycle 12, want 1", blk_start);
    end else begin
      o = q_obs.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL single_issue2: thr=%0d nc=%b want thr=%0d nc=%b", o.thr, o.nc, e.thr, e.nc); end
    end
    end_blk(1'b1);
    n_vec++; if (comp_done !== 1'b1 || thread_num !== 3'd3 || pending !== 8'h00 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_done: comp_done=%b thr=%0d pending=%h busy=%b want 1/3/00/0", comp_done, thread_num, pending, busy); end
    cyc(1);
    n_vec++; if (comp_done !== 1'b0 || err !== 1'b0 || q_obs.size() != 0) begin
      n_fail++; $display("FAIL single_after: comp_done=%b err=%b extra_issues=%0d want 0/0/0", comp_done, err, q_obs.size()); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_round_robin;
    iss_t o, e;
    bit   ok, fin;
    int   nblk;
    int   thr_l[3] = '{1, 5, 6};
    for (int ph = 0; ph < 2; ph++) begin
      do_reset;
      nblk = (ph == 0) ? 3 : 9;
      for (int k = 0; k < nblk; k++) q_exp.push_back('{thr: 3'(thr_l[k % 3]), nc: (k < 3)});
      enq(1, 1'b1); enq(5, 1'b1); enq(6, 1'b1);
      for (int k = 0; k < nblk; k++) begin
        fin = (ph == 0) || (k >= 6);
        e = q_exp.pop_front();
        wait_obs(ok);
        n_vec++;
        if (!ok) begin
          n_fail++; $display("FAIL rr_issue ph%0d blk%0d: no blk_start, want thr=%0d", ph, k, e.thr);
          break;
        end
        o = q_obs.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL rr_issue ph%0d blk%0d: thr=%0d nc=%b want thr=%0d nc=%b", ph, k, o.thr, o.nc, e.thr, e.nc); end
        end_blk(fin);
        n_vec++; if (comp_done !== fin) begin
          n_fail++; $display("FAIL rr_comp_done ph%0d blk%0d: got %b want %b", ph, k, comp_done, fin); end
      end
      cyc(2);
      n_vec++; if (pending !== 8'h00 || busy !== 1'b0 || q_obs.size() != 0) begin
        n_fail++; $display("FAIL rr_drain ph%0d: pending=%h busy=%b issues=%0d want 00/0/0", ph, pending, busy, q_obs.size()); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_wrap;
    iss_t o, e;
    bit   ok;
    int   thr_l[3] = '{6, 7, 2};
    do_reset;
    for (int k = 0; k < 3; k++) q_exp.push_back('{thr: 3'(thr_l[k]), nc: 1'b1});
    enq(6, 1'b1);           // pointer becomes 7 when 6 issues
    cyc(1);
    enq(2, 1'b1); enq(7, 1'b1);
    n_vec++; if (pending !== 8'h84) begin
      n_fail++; $display("FAIL wrap_pending: got %h want 84", pending); end
    for (int k = 0; k < 3; k++) begin
      e = q_exp.pop_front();
      wait_obs(ok);
      n_vec++;
      if (!ok) begin
        n_fail++; $display("FAIL wrap_issue blk%0d: no blk_start, want thr=%0d", k, e.thr);
        break;
      end
      o = q_obs.pop_front();
      if (o !== e) begin n_fail++; $display("FAIL wrap_issue blk%0d: thr=%0d want %0d", k, o.thr, e.thr); end
      end_blk(1'b1);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_errors;
    // duplicate request for a pending thread
    do_reset;
    enq(0, 1'b1); enq(4, 1'b1);                     // cycle 2: thread 0 in flight
    n_vec++; if (err !== 1'b0 || pending !== 8'h10) begin
      n_fail++; $display("FAIL err_pre: err=%b pending=%h want 0/10", err, pending); end
    enq(4, 1'b0);
    n_vec++; if (err !== 1'b1 || pending !== 8'h10) begin
      n_fail++; $display("FAIL err_dup: err=%b pending=%h want 1/10", err, pending); end
    // blk_end together with a request for a different thread
    blk_end = 1'b1; comp_fin = 1'b1;
    req_wr_en = 1'b1; req_thread_num = 3'd3; req_new_comp = 1'b1;
    cyc(1);
    blk_end = 1'b0; comp_fin = 1'b0; req_wr_en = 1'b0;
    n_vec++; if (comp_done !== 1'b1 || pending !== 8'h18 || err !== 1'b1) begin
      n_fail++; $display("FAIL err_same_cycle: comp_done=%b pending=%h err=%b want 1/18/1", comp_done, pending, err); end

    // stray blk_end while idle
    do_reset;
    end_blk(1'b1);
    n_vec++; if (err !== 1'b1 || comp_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL err_stray_end: err=%b comp_done=%b busy=%b want 1/0/0", err, comp_done, busy); end

    // request for the in-flight thread on its blk_end cycle
    do_reset;
    enq(2, 1'b0);
    cyc(1);                                         // cycle 2: thread 2 in flight
    blk_end = 1'b1; comp_fin = 1'b0;
    req_wr_en = 1'b1; req_thread_num = 3'd2; req_new_comp = 1'b1;
    cyc(1);
    blk_end = 1'b0; req_wr_en = 1'b0;
    n_vec++; if (err !== 1'b1 || pending !== 8'h04) begin
      n_fail++; $display("FAIL err_inflight: err=%b pending=%h want 1/04", err, pending); end
    cyc(1);
    n_vec++; if (blk_start !== 1'b1 || thread_num !== 3'd2 || new_comp !== 1'b0) begin
      n_fail++; $display("FAIL err_inflight_reissue: blk_start=%b thr=%0d nc=%b want 1/2/0", blk_start, thread_num, new_comp); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_watchdog;
    do_reset;
    enq(5, 1'b1);
    cyc(1);                                         // cycle 2: blk_start
    n_vec++; if (blk_start !== 1'b1 || thread_num !== 3'd5) begin
      n_fail++; $display("FAIL wd_start: blk_start=%b thr=%0d want 1/5", blk_start, thread_num); end
    cyc(14);
    n_vec++; if (err !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wd_early: err=%b busy=%b at 14 cycles, want 0/1", err, busy); end
    cyc(1);
    n_vec++; if (err !== 1'b1 || busy !== 1'b0 || pending !== 8'h00 || comp_done !== 1'b0) begin
      n_fail++; $display("FAIL wd_expire: err=%b busy=%b pending=%h comp_done=%b want 1/0/00/0", err, busy, pending, comp_done); end
    cyc(4);
    n_vec++; if (q_obs.size() != 1 || pending !== 8'h00) begin
      n_fail++; $display("FAIL wd_no_requeue: issues=%0d pending=%h want 1/00", q_obs.size(), pending); end
    enq(1, 1'b1);
    cyc(1);
    n_vec++; if (blk_start !== 1'b1 || thread_num !== 3'd1) begin
      n_fail++; $display("FAIL wd_back_idle: blk_start=%b thr=%0d want 1/1", blk_start, thread_num); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_async_reset;
    do_reset;
    enq(0, 1'b1); enq(2, 1'b1); enq(5, 1'b1);
    n_vec++; if (pending !== 8'h24 || busy !== 1'b1) begin
      n_fail++; $display("FAIL ar_setup: pending=%h busy=%b want 24/1", pending, busy); end
    #2 RST_N = 1'b0;
    #1;
    n_vec++; if ({blk_start, new_comp, busy, comp_done, err} !== 5'b0 || pending !== 8'h00 || thread_num !== 3'd0) begin
      n_fail++; $display("FAIL ar_clear: ctrl=%b pending=%h thr=%0d want 00000/00/0",
                         {blk_start, new_comp, busy, comp_done, err}, pending, thread_num); end
    @(negedge CLK);
    RST_N = 1'b1;
    q_obs.delete();
    cyc(5);
    n_vec++; if (q_obs.size() != 0 || pending !== 8'h00 || comp_done !== 1'b0) begin
      n_fail++; $display("FAIL ar_quiet: issues=%0d pending=%h comp_done=%b want 0/00/0", q_obs.size(), pending, comp_done); end
    enq(1, 1'b1);
    cyc(1);
    n_vec++; if (blk_start !== 1'b1 || thread_num !== 3'd1 || new_comp !== 1'b1) begin
      n_fail++; $display("FAIL ar_restart: blk_start=%b thr=%0d nc=%b want 1/1/1", blk_start, thread_num, new_comp); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_wrap;
    test_errors;
    test_watchdog;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
